bit_serial_adder: RTL and testbench
===================================

// Module: bit_serial_adder
// PURPOSE
//   Multi-bit adder built around the existing 1-bit full adder, one bit per clock, LSB first.
//   Sits directly upstream and downstream of full_adder_1_bit:
//   - drives the full adder's a/b/cin from internal shift registers;
//   - consumes its sum/carry into a result shift register and a carry flip-flop.
//   Valid/ready handshake on both operand input and result output.
// PARAMETERS
//   WIDTH  8  operand/result width in bits; legal range >= 1
// PORTS
//   clk        in   1      system clock; all state updates on rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      operands a/b/cin present
//   in_ready   out  1      block can accept operands
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   cin        in   1      carry in
//   fa_a       out  1      to full adder a
//   fa_b       out  1      to full adder b
//   fa_cin     out  1      to full adder cin
//   fa_sum     in   1      from full adder sum (combinational)
//   fa_carry   in   1      from full adder carry (combinational)
//   out_valid  out  1      sum/cout hold a completed result
//   out_ready  in   1      consumer takes result
//   sum        out  WIDTH  result bits
//   cout       out  1      final carry out
// BEHAVIOUR
//   Reset: one clk edge with rst=1 gives state=IDLE, and all of the following are 0:
//     sum, cout, out_valid, fa_a/fa_b/fa_cin, the bit counter, and the a/b shift registers.
//     in_ready=0 while rst=1, and 1 from the first cycle after rst falls.
//   FSM, 3 states:
//   - IDLE: in_ready=1.
//     in_valid=1 at an edge: latch a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, go to RUN.
//   - RUN: in_ready=0.
//     Combinational drive: fa_a=a_sh[0], fa_b=b_sh[0], fa_cin=carry.
//     Each edge:
//       sum_sh<={fa_sum,sum_sh[WIDTH-1:1]}; carry<=fa_carry;
//       a_sh/b_sh shift right by 1 with 0 fill; cnt<=cnt+1.
//     On the edge where cnt==WIDTH-1: go to DONE with sum<=final sum_sh and cout<=fa_carry.
//   - DONE: out_valid=1, in_ready=0. sum/cout stable while out_valid=1.
//     out_ready=1 at an edge: out_valid<=0, go to IDLE.
//   Outside RUN, fa_a/fa_b/fa_cin=0.
//   Latency: operands accepted at edge E give out_valid=1 after edge E+WIDTH.
//   Throughput: one result per WIDTH+2 cycles at best.
//   Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). No overflow flag.
//   Counter width $clog2(WIDTH+1); WIDTH=1 gives a single RUN cycle.
//   Boundaries:
//   - in_valid while in RUN/DONE: ignored, no latch; the upstream must hold it.
//   - out_ready=1 outside DONE: no effect.
//   - out_ready held low: stay in DONE indefinitely; sum/cout/out_valid unchanged.
//   - rst=1 in any state, including mid-RUN: abort with no partial result, IDLE next cycle.
//   - After handshake, sum/cout keep the last result; they are meaningful only when out_valid=1.
// TESTING
//   1. rst high 2 cycles -> out_valid=0, sum=0, cout=0, fa_*=0; in_ready=1 after rst drops.
//   2. WIDTH=8, a=8'h0F, b=8'h01, cin=0, out_ready=1
//      -> out_valid 8 cycles after accept; sum=8'h10, cout=0.
//   3. a=8'hFF, b=8'h01, cin=1 -> sum=8'h01, cout=1.
//      Check fa_cin=1 every RUN cycle after the first.
//   4. a=8'hA5, b=8'h5A, cin=1, out_ready low 5 cycles after out_valid
//      -> sum=8'h00, cout=1, held stable; out_valid drops the cycle after out_ready=1.
//   5. In RUN, pulse in_valid with a=8'h33 -> ignored, result of the in-flight op unchanged.
//      Assert rst at RUN cycle 4 -> IDLE, out_valid never rises.
//   6. 100 random a/b/cin against golden a+b+cin, random out_ready stalls -> all match, no lost or duplicated results.

Source files
------------

// File: rtl/bit_serial_adder.sv
// ---------------------------------------------------------------------------
// bit_serial_adder
//
// Adds two WIDTH-bit operands plus a carry-in one bit per clock, LSB first,
// by time-multiplexing an external 1-bit full adder. Operands arrive and
// results leave through valid/ready handshakes.
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   in_valid   operands a/b/cin are present
//   in_ready   adder is idle and can accept operands
//   a, b       WIDTH-bit operands
//   cin        carry in
//   fa_a       bit of a presented to the full adder
//   fa_b       bit of b presented to the full adder
//   fa_cin     running carry presented to the full adder
//   fa_sum     sum bit returned by the full adder (combinational)
//   fa_carry   carry bit returned by the full adder (combinational)
//   out_valid  sum/cout hold a completed result
//   out_ready  consumer takes the result
//   sum        WIDTH-bit result
//   cout       final carry out
// ---------------------------------------------------------------------------
module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_aShift;
    logic [WIDTH-1:0]   r_bShift;
    logic [WIDTH-1:0]   r_sumShift;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic               r_cout;
    logic               r_outValid;
    logic [CNT_W-1:0]   r_count;

    logic [WIDTH:0]     w_sumConcat;
    logic [WIDTH-1:0]   w_sumNext;
    logic               w_lastBit;
    logic               w_running;

    // New sum bits enter at the MSB so that after WIDTH shifts the first
    // (LSB) bit has arrived at position 0. Taking the upper WIDTH bits of the
    // concatenation keeps this valid for WIDTH=1 as well.
    assign w_sumConcat = {fa_sum, r_sumShift};
    assign w_sumNext   = w_sumConcat[WIDTH:1];
    assign w_lastBit   = (r_count == CNT_W'(WIDTH - 1));
    assign w_running   = (r_state == RUN);

    // The full adder sits in a combinational loop with this block, so its
    // inputs come straight from the shift registers and are parked at zero
    // whenever no addition is in progress.
    assign fa_a   = w_running & r_aShift[0];
    assign fa_b   = w_running & r_bShift[0];
    assign fa_cin = w_running & r_carry;

    // Ready is held low during reset itself so nothing is accepted on the
    // reset edge, and rises as soon as reset is released.
    assign in_ready  = (r_state == IDLE) && !rst;
    assign out_valid = r_outValid;
    assign sum       = r_sum;
    assign cout      = r_cout;

    // Sequencer: latch operands in IDLE, clock one bit through the full adder
    // per cycle in RUN, then hold the result in DONE until it is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_aShift   <= '0;
            r_bShift   <= '0;
            r_sumShift <= '0;
            r_sum      <= '0;
            r_carry    <= 1'b0;
            r_cout     <= 1'b0;
            r_outValid <= 1'b0;
            r_count    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_aShift <= a;
                        r_bShift <= b;
                        r_carry  <= cin;
                        r_count  <= '0;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    r_sumShift <= w_sumNext;
                    r_carry    <= fa_carry;
                    r_aShift   <= r_aShift >> 1;
                    r_bShift   <= r_bShift >> 1;
                    r_count    <= r_count + 1'b1;
                    if (w_lastBit) begin
                        r_sum      <= w_sumNext;
                        r_cout     <= fa_carry;
                        r_outValid <= 1'b1;
                        r_state    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_outValid <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_bit_serial_adder
//
// Drives bit_serial_adder with directed and random operands. A behavioural
// full adder closes the loop around the DUT. Every accepted operand set
// pushes its golden {cout,sum} onto a queue, which a monitor pops when the
// result handshake occurs.
// ---------------------------------------------------------------------------
module tb_bit_serial_adder;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             fa_a;
    logic             fa_b;
    logic             fa_cin;
    logic             fa_sum;
    logic             fa_carry;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    logic             randomReady;
    logic             manualReady;
    logic             rndBit;

    int               numChecks = 0;
    int               numErrors = 0;
    int               pushed    = 0;
    int               popped    = 0;
    int               flushed   = 0;
    logic [WIDTH:0]   expQ[$];

    always #5 clk = ~clk;

    // Behavioural stand-in for the 1-bit full adder the DUT drives.
    assign fa_sum   = fa_a ^ fa_b ^ fa_cin;
    assign fa_carry = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

    assign out_ready = randomReady ? rndBit : manualReady;

    bit_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .fa_a      (fa_a),
        .fa_b      (fa_b),
        .fa_cin    (fa_cin),
        .fa_sum    (fa_sum),
        .fa_carry  (fa_carry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numErrors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Present one operand set, wait for acceptance, record its golden result.
    task automatic applyStimulus(input logic [WIDTH-1:0] opA, input logic [WIDTH-1:0] opB,
                                 input logic opCin);
        int             waited;
        logic           accepted;
        logic [WIDTH:0] expVal;
        waited   = 0;
        accepted = 1'b0;
        a        = opA;
        b        = opB;
        cin      = opCin;
        in_valid = 1'b1;
        while (!accepted && waited < 200) begin
            @(negedge clk);
            if (in_ready && !rst) accepted = 1'b1;
            else waited++;
        end
        checkOutput("acceptTimeout", 32'(accepted), 32'd1);
        if (accepted) begin
            expVal = {1'b0, opA} + {1'b0, opB} + (WIDTH + 1)'(opCin);
            expQ.push_back(expVal);
            pushed++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait (bounded) until every expected result has been consumed.
    task automatic waitDrain(input int limit);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("drainTimeout", 32'(expQ.size()), 32'd0);
    endtask

    // Random backpressure source, updated just after each rising edge.
    initial begin
        rndBit = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rndBit = 1'($urandom_range(0, 1));
        end
    end

    // Result monitor: while a result is offered it must equal the oldest
    // expected value; it is retired when the handshake completes.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("spuriousResult", 32'(expQ.size()), 32'd1);
                end else begin
                    checkOutput(out_ready ? "result" : "holdStable",
                                32'({cout, sum}), 32'(expQ[0]));
                    if (out_ready) begin
                        void'(expQ.pop_front());
                        popped++;
                    end
                end
            end
        end
    end

    // Hard stop in case some sequence wedges.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got time limit, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequences followed by a random run.
    initial begin
        int   latency;
        logic sawValid;

        rst         = 1'b1;
        in_valid    = 1'b0;
        a           = '0;
        b           = '0;
        cin         = 1'b0;
        randomReady = 1'b0;
        manualReady = 1'b1;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstOutValid", 32'(out_valid), 32'd0);
        checkOutput("rstSum", 32'(sum), 32'd0);
        checkOutput("rstCout", 32'(cout), 32'd0);
        checkOutput("rstFa", 32'({fa_a, fa_b, fa_cin}), 32'd0);
        checkOutput("rstInReady", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("readyAfterReset", 32'(in_ready), 32'd1);

        // 0x0F + 0x01 + 0: latency of WIDTH edges from acceptance.
        applyStimulus(8'h0F, 8'h01, 1'b0);
        latency = 0;
        for (int n = 1; n <= 20 && latency == 0; n++) begin
            @(posedge clk);
            #1;
            if (out_valid) latency = n;
        end
        checkOutput("latency", 32'(latency), 32'(WIDTH));
        waitDrain(20);

        // 0xFF + 0x01 + 1: carry stays high through every bit.
        applyStimulus(8'hFF, 8'h01, 1'b1);
        for (int n = 1; n < WIDTH; n++) begin
            @(posedge clk);
            #1;
            checkOutput("faCinRun", 32'(fa_cin), 32'd1);
        end
        waitDrain(20);

        // 0xA5 + 0x5A + 1 with the consumer stalled for 5 cycles.
        manualReady = 1'b0;
        applyStimulus(8'hA5, 8'h5A, 1'b1);
        for (int n = 0; n < 20 && !out_valid; n++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("validRise", 32'(out_valid), 32'd1);
        repeat (5) begin
            @(posedge clk);
            #1;
            checkOutput("holdValid", 32'(out_valid), 32'd1);
            checkOutput("holdSum", 32'({cout, sum}), 32'h100);
        end
        manualReady = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("validDrop", 32'(out_valid), 32'd0);
        checkOutput("readyAfterDone", 32'(in_ready), 32'd1);
        waitDrain(5);

        // in_valid pulse while busy must be ignored.
        applyStimulus(8'h12, 8'h34, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        a        = 8'h33;
        b        = 8'h33;
        in_valid = 1'b1;
        checkOutput("busyNotReady", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        waitDrain(20);

        // Reset mid-RUN aborts the operation with no result.
        applyStimulus(8'h77, 8'h11, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abortInReady", 32'(in_ready), 32'd0);
        checkOutput("abortFa", 32'({fa_a, fa_b, fa_cin}), 32'd0);
        rst = 1'b0;
        flushed += expQ.size();
        expQ.delete();
        sawValid = 1'b0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (out_valid) sawValid = 1'b1;
        end
        checkOutput("abortNoValid", 32'(sawValid), 32'd0);
        checkOutput("readyAfterAbort", 32'(in_ready), 32'd1);

        // Random operands with random consumer stalls.
        randomReady = 1'b1;
        for (int i = 0; i < 100; i++) begin
            applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)));
        end
        waitDrain(400);
        checkOutput("resultCount", 32'(popped), 32'(pushed - flushed));

        $display("Result: errors=%0d of %0d checks", numErrors, numChecks);
        $finish;
    end

endmodule
